// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch
// Purpose  : Word-addressed PC plus IF/ID register with stall/branch/jump
//            redirect and halt-on-HALT_WORD.
// Revision : 1.0
// ============================================================================
module instruction_fetch #(
  parameter int          ADDR_W    = 5,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_base,
  input  logic [15:0]       branch_imm,
  input  logic              jump,
  input  logic [25:0]       jump_index,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic [31:0]       instr_in,
  output logic [31:0]       if_id_instr,
  output logic [ADDR_W-1:0] if_id_pc1,
  output logic              if_id_valid,
  output logic              halted
);

  localparam logic [1:0] S_START = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] pc1_q, pc1_d;
  logic              valid_q, valid_d;

  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] branch_target;
  logic [ADDR_W-1:0] jump_target;
  logic              is_halt;

  assign pc_inc        = pc_q + ADDR_W'(1);
  // Signed offset is sign-extended then wrapped modulo the address space.
  assign branch_target = branch_base + ADDR_W'($signed(branch_imm));
  assign jump_target   = ADDR_W'(jump_index);
  assign is_halt       = (instr_in == HALT_WORD);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_START;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pc1_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc1_q   <= pc1_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_START: state_d = S_RUN;
      S_RUN:   if (!jump && !branch_taken && !stall && is_halt) state_d = S_HALT;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_START;
    endcase
  end

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc1_d   = pc1_q;
    valid_d = valid_q;
    case (state_q)
      S_RUN: begin
        if (jump) begin
          pc_d    = jump_target;
          instr_d = '0;
          valid_d = 1'b0;
        end else if (branch_taken) begin
          pc_d    = branch_target;
          instr_d = '0;
          valid_d = 1'b0;
        end else if (!stall) begin
          // The halt word itself is delivered; only the PC stops advancing.
          pc_d    = is_halt ? pc_q : pc_inc;
          instr_d = instr_in;
          pc1_d   = pc_inc;
          valid_d = 1'b1;
        end
      end
      S_HALT: begin
        instr_d = '0;
        valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign instr_addr  = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc1   = pc1_q;
  assign if_id_valid = valid_q;
  assign halted      = (state_q == S_HALT);

endmodule
`default_nettype wire
